z80_write_snoop: RTL and testbench

//  Upstream capture stage for the ZX frame memory. Snoops the asynchronous Z80 bus in the

---
 rtl/zx_pkg.sv | 32 +++
 rtl/zx_sync_fifo.sv | 60 ++++++
 rtl/z80_write_snoop.sv | 177 +++++++++++++++++
 tb/tb_z80_write_snoop.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zx_pkg.sv
// Shared constants and types for the ZX frame-memory write snoop.
// Screen window, ULA port decode, capture FSM states and access kinds.
package zx_pkg;

    localparam logic [15:0] SCREEN_BASE   = 16'h4000;
    localparam logic [15:0] SCREEN_LAST   = 16'h5AFF;
    localparam logic [15:0] ULA_PORT_MASK = 16'h0001;

    localparam int ADDR_W  = 13;
    localparam int DATA_W  = 8;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_COMMIT = 2'd2
    } snoop_state_e;

    typedef enum logic {
        KIND_MEM = 1'b0,
        KIND_IO  = 1'b1
    } access_kind_e;

    function automatic logic is_screen_addr(input logic [15:0] addr);
        return (addr >= SCREEN_BASE) && (addr <= SCREEN_LAST);
    endfunction

    function automatic logic is_ula_port(input logic [15:0] addr);
        return (addr & ULA_PORT_MASK) == 16'h0000;
    endfunction

endpackage

// File: rtl/zx_sync_fifo.sv
// First-word-fall-through FIFO: head entry always on o_data; a push into a full
// FIFO is accepted only when a pop happens in the same cycle, otherwise o_drop.
module zx_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 21
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_drop  = i_push && w_full && !w_pop;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/z80_write_snoop.sv
// Snoops the asynchronous Z80 bus in the pixel clock domain; queues screen writes
// as {offset, data} for the frame-memory stage and tracks the ULA border colour.
module z80_write_snoop
    import zx_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_DELAY = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] A,
    input  logic [7:0]  D,
    input  logic        WR,
    input  logic        MREQ,
    input  logic        IORQ,
    output logic        WR_VALID,
    input  logic        WR_READY,
    output logic [12:0] WR_ADDR,
    output logic [7:0]  WR_DATA,
    output logic [2:0]  BORDER,
    output logic        OVERFLOW
);

    localparam int DLY_W = 3;

    logic r_rst_meta;
    logic r_rst_sync;
    logic w_rst_n;

    logic        r_wr_s1,   r_wr_s2,   r_wr_prev;
    logic        r_mreq_s1, r_mreq_s2;
    logic        r_iorq_s1, r_iorq_s2;
    logic [15:0] r_a_s1,    r_a_s2;
    logic [7:0]  r_d_s1,    r_d_s2;
    logic        w_wr_fall;

    snoop_state_e        r_state, w_state_nxt;
    access_kind_e        r_kind,  w_kind_nxt;
    logic [DLY_W-1:0]    r_cnt,   w_cnt_nxt;
    logic [ADDR_W-1:0]   r_offset, w_offset_nxt;
    logic [DATA_W-1:0]   r_data,  w_data_nxt;
    logic                w_push;
    logic                w_border_load;

    logic [ENTRY_W-1:0]  w_head;
    logic                w_empty;
    logic                w_drop;
    logic [2:0]          r_border;
    logic                r_overflow;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end
    assign w_rst_n = r_rst_sync;

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_s1   <= 1'b1;
            r_wr_s2   <= 1'b1;
            r_wr_prev <= 1'b1;
            r_mreq_s1 <= 1'b1;
            r_mreq_s2 <= 1'b1;
            r_iorq_s1 <= 1'b1;
            r_iorq_s2 <= 1'b1;
            r_a_s1    <= '1;
            r_a_s2    <= '1;
            r_d_s1    <= '1;
            r_d_s2    <= '1;
        end else begin
            r_wr_s1   <= WR;
            r_wr_s2   <= r_wr_s1;
            r_wr_prev <= r_wr_s2;
            r_mreq_s1 <= MREQ;
            r_mreq_s2 <= r_mreq_s1;
            r_iorq_s1 <= IORQ;
            r_iorq_s2 <= r_iorq_s1;
            r_a_s1    <= A;
            r_a_s2    <= r_a_s1;
            r_d_s1    <= D;
            r_d_s2    <= r_d_s1;
        end
    end

    assign w_wr_fall = r_wr_prev && !r_wr_s2;

    always_comb begin
        w_state_nxt   = r_state;
        w_kind_nxt    = r_kind;
        w_cnt_nxt     = r_cnt;
        w_offset_nxt  = r_offset;
        w_data_nxt    = r_data;
        w_push        = 1'b0;
        w_border_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr_fall) begin
                    // Screen offset is kept directly; IO accesses never use it.
                    w_offset_nxt = ADDR_W'(r_a_s2 - SCREEN_BASE);
                    w_cnt_nxt    = DLY_W'(DATA_DELAY - 1);
                    if (!r_mreq_s2 && is_screen_addr(r_a_s2)) begin
                        w_kind_nxt  = KIND_MEM;
                        w_state_nxt = S_WAIT;
                    end else if (!r_iorq_s2 && is_ula_port(r_a_s2)) begin
                        w_kind_nxt  = KIND_IO;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_data_nxt  = r_d_s2;
                    w_state_nxt = S_COMMIT;
                end else begin
                    w_cnt_nxt = r_cnt - DLY_W'(1);
                end
            end
            S_COMMIT: begin
                w_push        = (r_kind == KIND_MEM);
                w_border_load = (r_kind == KIND_IO);
                w_state_nxt   = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= S_IDLE;
            r_kind     <= KIND_MEM;
            r_cnt      <= '0;
            r_offset   <= '0;
            r_data     <= '0;
            r_border   <= 3'b000;
            r_overflow <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_kind   <= w_kind_nxt;
            r_cnt    <= w_cnt_nxt;
            r_offset <= w_offset_nxt;
            r_data   <= w_data_nxt;
            if (w_border_load) begin
                r_border <= r_data[2:0];
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    zx_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (w_rst_n),
        .i_push  (w_push),
        .i_data  ({r_offset, r_data}),
        .i_pop   (WR_READY),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    assign WR_VALID = !w_empty;
    assign WR_ADDR  = w_head[ENTRY_W-1:DATA_W];
    assign WR_DATA  = w_head[DATA_W-1:0];
    assign BORDER   = r_border;
    assign OVERFLOW = r_overflow;

endmodule

// File: tb/tb_z80_write_snoop.sv
// Bench for z80_write_snoop: randomized Z80 bus cycles against a queue-based model
// of which writes land in the frame FIFO, which set the border, and which are dropped.
module tb_z80_write_snoop;

    localparam int DEPTH      = 4;
    localparam int DATA_DELAY = 2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] A = 16'hFFFF;
    logic [7:0]  D = 8'hFF;
    logic        WR = 1'b1;
    logic        MREQ = 1'b1;
    logic        IORQ = 1'b1;
    logic        WR_READY = 1'b0;
    logic        WR_VALID;
    logic [12:0] WR_ADDR;
    logic [7:0]  WR_DATA;
    logic [2:0]  BORDER;
    logic        OVERFLOW;

    int checks = 0;
    int errors = 0;
    int pop_count = 0;

    logic [20:0] exp_q[$];
    logic [2:0]  exp_border = 3'b000;
    logic        exp_overflow = 1'b0;

    z80_write_snoop #(
        .DEPTH      (DEPTH),
        .DATA_DELAY (DATA_DELAY)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .A        (A),
        .D        (D),
        .WR       (WR),
        .MREQ     (MREQ),
        .IORQ     (IORQ),
        .WR_VALID (WR_VALID),
        .WR_READY (WR_READY),
        .WR_ADDR  (WR_ADDR),
        .WR_DATA  (WR_DATA),
        .BORDER   (BORDER),
        .OVERFLOW (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every handshake must match the oldest expected entry.
    always @(negedge CLK) begin
        if (WR_VALID === 1'b1 && WR_READY === 1'b1) begin
            logic [20:0] exp;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got addr=%h data=%h, required no entry", WR_ADDR, WR_DATA);
            end else begin
                exp = exp_q.pop_front();
                if ({WR_ADDR, WR_DATA} !== exp) begin
                    errors++;
                    $display("FAIL pop_entry: got addr=%h data=%h, required addr=%h data=%h",
                             WR_ADDR, WR_DATA, exp[20:8], exp[7:0]);
                end
            end
            pop_count++;
        end
    end

    // Reference model: decides the fate of one completed Z80 write.
    task automatic model_write(input logic [15:0] a, input logic [7:0] d, input bit io);
        if (!io && a >= 16'h4000 && a <= 16'h5AFF) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({13'(a - 16'h4000), d});
            else exp_overflow = 1'b1;
        end else if (io && (a % 2 == 0)) begin
            exp_border = d[2:0];
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input bit io);
        @(posedge CLK); #1;
        A = a; D = d;
        if (io) IORQ = 1'b0; else MREQ = 1'b0;
        @(posedge CLK); #1;
        WR = 1'b0;
        model_write(a, d, io);
        repeat (10) @(posedge CLK);
        #1 WR = 1'b1;
        @(posedge CLK); #1;
        MREQ = 1'b1; IORQ = 1'b1;
        A = 16'($urandom_range(0, 16'hFFFF)); D = 8'($urandom_range(0, 255));
        repeat (3) @(posedge CLK);
    endtask

    task automatic test_reset;
        #1 RESET = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            A = 16'($urandom_range(0, 16'hFFFF)); D = 8'($urandom_range(0, 255));
            WR = 1'($urandom_range(0, 1)); MREQ = 1'($urandom_range(0, 1));
            IORQ = 1'($urandom_range(0, 1)); WR_READY = 1'($urandom_range(0, 1));
            @(negedge CLK);
            checks++;
            if (WR_VALID !== 1'b0 || BORDER !== 3'b000 || OVERFLOW !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: got valid=%b border=%b ovf=%b, required 0/000/0",
                         WR_VALID, BORDER, OVERFLOW);
            end
        end
        checks++;
        if (WR_ADDR !== 13'h0 || WR_DATA !== 8'h0) begin
            errors++;
            $display("FAIL reset_head: got addr=%h data=%h, required 0000/00", WR_ADDR, WR_DATA);
        end
        @(posedge CLK); #1;
        WR = 1'b1; MREQ = 1'b1; IORQ = 1'b1; WR_READY = 1'b0;
        @(posedge CLK); #1 RESET = 1'b1;
        repeat (4) @(posedge CLK);
    endtask

    task automatic test_mem_latency;
        logic [15:0] addrs [2];
        logic [7:0]  datas [2];
        int p0;
        addrs[0] = 16'h4000; datas[0] = 8'hA5;
        addrs[1] = 16'h5AFF; datas[1] = 8'($urandom_range(0, 255));
        WR_READY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            p0 = pop_count;
            @(posedge CLK); #1;
            A = addrs[i]; D = datas[i]; MREQ = 1'b0;
            @(posedge CLK); #1;
            WR = 1'b0;
            model_write(addrs[i], datas[i], 1'b0);
            // WR_VALID must pulse once, DATA_DELAY+2 edges after wr_fall (2 sync edges later).
            for (int c = 1; c <= 9; c++) begin
                @(negedge CLK);
                checks++;
                if (WR_VALID !== (c == DATA_DELAY + 5)) begin
                    errors++;
                    $display("FAIL latency_%0d: cycle %0d got valid=%b, required %b",
                             i, c, WR_VALID, (c == DATA_DELAY + 5));
                end
            end
            @(posedge CLK); #1;
            WR = 1'b1;
            @(posedge CLK); #1 MREQ = 1'b1;
            repeat (3) @(posedge CLK);
            checks++;
            if (pop_count != p0 + 1) begin
                errors++;
                $display("FAIL latency_pops_%0d: got %0d pops, required 1", i, pop_count - p0);
            end
        end
    endtask

    task automatic test_no_push;
        int p0;
        p0 = pop_count;
        WR_READY = 1'b1;
        bus_write(16'h3FFF, 8'($urandom_range(0, 255)), 1'b0);
        bus_write(16'h5B00, 8'($urandom_range(0, 255)), 1'b0);
        // Read cycle: MREQ active on a screen address, WR never falls.
        @(posedge CLK); #1;
        A = 16'h4100; D = 8'h3C; MREQ = 1'b0;
        repeat (10) @(posedge CLK);
        #1 MREQ = 1'b1;
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (pop_count != p0) begin
            errors++;
            $display("FAIL no_push_pops: got %0d pops, required 0", pop_count - p0);
        end
        checks++;
        if (OVERFLOW !== exp_overflow || WR_VALID !== 1'b0) begin
            errors++;
            $display("FAIL no_push_flags: got ovf=%b valid=%b, required ovf=%b valid=0",
                     OVERFLOW, WR_VALID, exp_overflow);
        end
    endtask

    task automatic test_border;
        int p0;
        p0 = pop_count;
        bus_write(16'h00FE, 8'h05, 1'b1);
        @(negedge CLK);
        checks++;
        if (BORDER !== 3'b101) begin
            errors++;
            $display("FAIL border_fe: got %b, required 101", BORDER);
        end
        bus_write(16'h00FF, 8'($urandom_range(0, 255)), 1'b1);
        @(negedge CLK);
        checks++;
        if (BORDER !== exp_border) begin
            errors++;
            $display("FAIL border_ff: got %b, required %b", BORDER, exp_border);
        end
        checks++;
        if (pop_count != p0) begin
            errors++;
            $display("FAIL border_pops: got %0d pops, required 0", pop_count - p0);
        end
    endtask

    task automatic test_random_mix;
        logic [15:0] a;
        bit io;
        WR_READY = 1'b1;
        for (int i = 0; i < 12; i++) begin
            io = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'h4000, 16'h5AFF))
                                             : 16'($urandom_range(0, 16'hFFFF));
            bus_write(a, 8'($urandom_range(0, 255)), io);
            @(negedge CLK);
            checks++;
            if (BORDER !== exp_border || OVERFLOW !== exp_overflow) begin
                errors++;
                $display("FAIL random_%0d: a=%h io=%0d got border=%b ovf=%b, required %b/%b",
                         i, a, io, BORDER, OVERFLOW, exp_border, exp_overflow);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got %0d entries outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_overflow;
        int p0;
        WR_READY = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            bus_write(16'($urandom_range(16'h4000, 16'h5AFF)), 8'($urandom_range(0, 255)), 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++;
            if (WR_VALID !== 1'b1 || {WR_ADDR, WR_DATA} !== exp_q[0]) begin
                errors++;
                $display("FAIL overflow_head_%0d: got valid=%b addr=%h data=%h, required 1/%h/%h",
                         i, WR_VALID, WR_ADDR, WR_DATA, exp_q[0][20:8], exp_q[0][7:0]);
            end
        end
        checks++;
        if (OVERFLOW !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flag: got %b, required 1", OVERFLOW);
        end
        p0 = pop_count;
        @(posedge CLK); #1 WR_READY = 1'b1;
        repeat (DEPTH + 4) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (pop_count - p0 != DEPTH || WR_VALID !== 1'b0) begin
            errors++;
            $display("FAIL overflow_drain: got %0d pops valid=%b, required %0d pops valid=0",
                     pop_count - p0, WR_VALID, DEPTH);
        end
        checks++;
        if (OVERFLOW !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got %b, required 1", OVERFLOW);
        end
    endtask

    task automatic test_reset_midop;
        int p0;
        WR_READY = 1'b0;
        bus_write(16'($urandom_range(16'h4000, 16'h5AFF)), 8'($urandom_range(0, 255)), 1'b0);
        bus_write(16'($urandom_range(16'h4000, 16'h5AFF)), 8'($urandom_range(0, 255)), 1'b0);
        @(posedge CLK); #1;
        A = 16'h4800; D = 8'h77; MREQ = 1'b0;
        @(posedge CLK); #1 WR = 1'b0;
        // Third edge after WR falls: capture is counting down in WAIT.
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        exp_q.delete();
        exp_overflow = 1'b0;
        exp_border = 3'b000;
        repeat (2) @(posedge CLK);
        #1 WR = 1'b1; MREQ = 1'b1;
        @(posedge CLK); #1 RESET = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            checks++;
            if (WR_VALID !== 1'b0 || OVERFLOW !== 1'b0 || BORDER !== exp_border) begin
                errors++;
                $display("FAIL midop_reset_%0d: got valid=%b ovf=%b border=%b, required 0/0/000",
                         i, WR_VALID, OVERFLOW, BORDER);
            end
        end
        checks++;
        if (WR_ADDR !== 13'h0 || WR_DATA !== 8'h0) begin
            errors++;
            $display("FAIL midop_head: got addr=%h data=%h, required 0000/00", WR_ADDR, WR_DATA);
        end
        p0 = pop_count;
        WR_READY = 1'b1;
        bus_write(16'($urandom_range(16'h4000, 16'h5AFF)), 8'($urandom_range(0, 255)), 1'b0);
        repeat (4) @(posedge CLK);
        checks++;
        if (pop_count != p0 + 1) begin
            errors++;
            $display("FAIL midop_recover: got %0d pops, required 1", pop_count - p0);
        end
    endtask

    initial begin
        test_reset();
        test_mem_latency();
        test_no_push();
        test_border();
        test_random_mix();
        test_overflow();
        test_reset_midop();
        repeat (5) @(posedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: got %0d entries outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
